// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// ALUOp and PCSource codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_BNE    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-output decoder for the multicycle controller.
// BNE strobes exist only when MC_CTRL_BNE_EN is defined.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource
);

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    ALUOp         = ALUOP_ADD;
    ALUSrcB       = SRCB_REG;
    PCSource      = PCSRC_ALU;

    case (state)
      S_FETCH: begin
        // PC/IR update only on the cycle the instruction word arrives
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_BOFF;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNE: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALUOP_SUB;
        PCWriteCondNe = 1'b1;
        PCSource      = PCSRC_ALUOUT;
      end
`endif
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic; outputs
// come from mc_ctrl_outdec. Define MC_CTRL_BNE_EN to add the BNE instruction.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W            = 6,
  parameter bit IDLE_ON_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            PCWriteCondNe,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            ALUSrcA,
  output logic            RegWrite,
  output logic            RegDst,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic            illegal_op,
  output logic [3:0]      state
);

  state_t     cur_state, nxt_state;
  logic [5:0] op6;
  logic       is_sw_q;
  logic       unused_opcode;

  // Only the top six bits are the MIPS opcode field; wider buses carry junk below.
  assign op6           = opcode[OP_W-1 -: 6];
  assign unused_opcode = ^opcode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_IDLE;
      is_sw_q   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      // Remember lw vs sw so MEMADR does not need the opcode again
      if (cur_state == S_DECODE)
        is_sw_q <= (op6 == OP_SW);
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    illegal_op = 1'b0;
    case (cur_state)
      S_IDLE:   nxt_state = S_FETCH;
      S_FETCH:  if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(op6)) begin
          nxt_state = S_MEMADR;
        end else begin
          case (op6)
            OP_RTYPE: nxt_state = S_EXEC;
            OP_BEQ:   nxt_state = S_BEQ;
            OP_J:     nxt_state = S_JUMP;
            OP_ADDI:  nxt_state = S_ADDIEX;
`ifdef MC_CTRL_BNE_EN
            OP_BNE:   nxt_state = S_BNE;
`endif
            default: begin
              illegal_op = 1'b1;
              nxt_state  = IDLE_ON_ILLEGAL ? S_IDLE : S_FETCH;
            end
          endcase
        end
      end
      S_MEMADR: nxt_state = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) nxt_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt_state = S_FETCH;
      S_EXEC:   nxt_state = S_ALUWB;
      S_ADDIEX: nxt_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP:
        nxt_state = S_FETCH;
`ifdef MC_CTRL_BNE_EN
      S_BNE:    nxt_state = S_FETCH;
`endif
      default:  nxt_state = S_IDLE;
    endcase
  end

  assign state = cur_state;

  mc_ctrl_outdec u_outdec (
    .state         (cur_state),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .PCWriteCond   (PCWriteCond),
    .PCWriteCondNe (PCWriteCondNe),
    .IorD          (IorD),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .MemtoReg      (MemtoReg),
    .ALUSrcA       (ALUSrcA),
    .RegWrite      (RegWrite),
    .RegDst        (RegDst),
    .ALUOp         (ALUOp),
    .ALUSrcB       (ALUSrcB),
    .PCSource      (PCSource)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: a default instance and a
// wide-opcode (OP_W=8) instance that parks in IDLE on illegal opcodes.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [5:0] opcode;
  logic [7:0] opcode_alt;

  logic PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] state;

  logic a_PCWrite, a_PCWriteCond, a_PCWriteCondNe, a_IorD, a_MemRead, a_MemWrite;
  logic a_IRWrite, a_MemtoReg, a_ALUSrcA, a_RegWrite, a_RegDst, a_illegal_op;
  logic [1:0] a_ALUOp, a_ALUSrcB, a_PCSource;
  logic [3:0] a_state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .illegal_op(illegal_op), .state(state)
  );

  multicycle_control #(.OP_W(8), .IDLE_ON_ILLEGAL(1'b1)) dut_alt (
    .clk(clk), .reset(reset), .opcode(opcode_alt), .mem_ready(mem_ready),
    .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .PCWriteCondNe(a_PCWriteCondNe),
    .IorD(a_IorD), .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite),
    .MemtoReg(a_MemtoReg), .ALUSrcA(a_ALUSrcA), .RegWrite(a_RegWrite), .RegDst(a_RegDst),
    .ALUOp(a_ALUOp), .ALUSrcB(a_ALUSrcB), .PCSource(a_PCSource),
    .illegal_op(a_illegal_op), .state(a_state)
  );

  // {PCWrite,PCWriteCond,PCWriteCondNe,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  //  ALUSrcA,RegWrite,RegDst}, ALUOp, ALUSrcB, PCSource, illegal_op
  logic [17:0] obs;
  assign obs = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
                IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst,
                ALUOp, ALUSrcB, PCSource, illegal_op};

  localparam logic [17:0] V_ZERO = '0;
  localparam logic [17:0] V_F1   = {11'b10001010000, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [17:0] V_F0   = {11'b00001000000, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [17:0] V_DEC  = {11'b00000000000, 2'b00, 2'b11, 2'b00, 1'b0};
  localparam logic [17:0] V_DILL = {11'b00000000000, 2'b00, 2'b11, 2'b00, 1'b1};
  localparam logic [17:0] V_ADR  = {11'b00000000100, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [17:0] V_MRD  = {11'b00011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] V_MWR  = {11'b00010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] V_MWB  = {11'b00000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] V_EXE  = {11'b00000000100, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] V_ALWB = {11'b00000000011, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] V_AIWB = {11'b00000000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [17:0] V_BEQ  = {11'b01000000100, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [17:0] V_JMP  = {11'b10000000000, 2'b00, 2'b00, 2'b10, 1'b0};
`ifdef MC_CTRL_BNE_EN
  localparam logic [17:0] V_BNE  = {11'b00100000100, 2'b01, 2'b00, 2'b01, 1'b0};
`endif

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [17:0] v;
    logic [3:0]  ast;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_one(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, got, want);
    end
  endtask

  task automatic expect_now(input string tag, input logic [3:0] st, input logic [17:0] v,
                            input logic [3:0] ast);
    exp_t e;
    sb.push_back('{tag: tag, st: st, v: v, ast: ast});
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check_one({e.tag, ".state"},   {28'd0, state},     {28'd0, e.st});
      check_one({e.tag, ".ctrl"},    {14'd0, obs},       {14'd0, e.v});
      check_one({e.tag, ".altst"},   {28'd0, a_state},   {28'd0, e.ast});
      check_one({e.tag, ".altill"},  {31'd0, a_illegal_op}, {31'd0, e.v[0]});
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check mid-low-phase.
  task automatic step(input string tag, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic [17:0] v, input logic [3:0] ast);
    @(negedge clk);
    opcode     = op;
    opcode_alt = {op, 2'b11};
    mem_ready  = mr;
    #1;
    expect_now(tag, st, v, ast);
  endtask

  initial begin
    reset      = 1'b1;
    mem_ready  = 1'b1;
    opcode     = '0;
    opcode_alt = '0;
    #2;
    expect_now("por", 4'd0, V_ZERO, 4'd0);
    @(negedge clk);
    expect_now("por.hold", 4'd0, V_ZERO, 4'd0);
    reset = 1'b0;

    // lw, no wait states: 1,2,3,4,5 then FETCH
    step("lw.fetch", 6'b111111, 1'b1, 4'd1, V_F1,  4'd1);
    step("lw.dec",   6'b100011, 1'b0, 4'd2, V_DEC, 4'd2);
    step("lw.adr",   6'b111111, 1'b0, 4'd3, V_ADR, 4'd3);
    step("lw.rd",    6'b101011, 1'b1, 4'd4, V_MRD, 4'd4);
    step("lw.wb",    6'b000000, 1'b0, 4'd5, V_MWB, 4'd5);

    // sw with two wait cycles in MEMWR
    step("sw.fetch", 6'b000000, 1'b1, 4'd1, V_F1,  4'd1);
    step("sw.dec",   6'b101011, 1'b0, 4'd2, V_DEC, 4'd2);
    step("sw.adr",   6'b100011, 1'b0, 4'd3, V_ADR, 4'd3);
    step("sw.wr0",   6'b000000, 1'b0, 4'd6, V_MWR, 4'd6);
    step("sw.wr1",   6'b000000, 1'b0, 4'd6, V_MWR, 4'd6);
    step("sw.wr2",   6'b000000, 1'b1, 4'd6, V_MWR, 4'd6);

    // R-type with one fetch wait
    step("r.fetch0", 6'b000000, 1'b0, 4'd1, V_F0,   4'd1);
    step("r.fetch1", 6'b000000, 1'b1, 4'd1, V_F1,   4'd1);
    step("r.dec",    6'b000000, 1'b0, 4'd2, V_DEC,  4'd2);
    step("r.exec",   6'b100011, 1'b0, 4'd7, V_EXE,  4'd7);
    step("r.wb",     6'b100011, 1'b0, 4'd8, V_ALWB, 4'd8);

    step("addi.fetch", 6'b000000, 1'b1, 4'd1,  V_F1,   4'd1);
    step("addi.dec",   6'b001000, 1'b0, 4'd2,  V_DEC,  4'd2);
    step("addi.ex",    6'b000000, 1'b0, 4'd11, V_ADR,  4'd11);
    step("addi.wb",    6'b000000, 1'b0, 4'd12, V_AIWB, 4'd12);

    step("beq.fetch", 6'b000000, 1'b1, 4'd1, V_F1,  4'd1);
    step("beq.dec",   6'b000100, 1'b0, 4'd2, V_DEC, 4'd2);
    step("beq.br",    6'b000000, 1'b0, 4'd9, V_BEQ, 4'd9);

    step("j.fetch", 6'b000000, 1'b1, 4'd1,  V_F1,  4'd1);
    step("j.dec",   6'b000010, 1'b0, 4'd2,  V_DEC, 4'd2);
    step("j.jump",  6'b000000, 1'b0, 4'd10, V_JMP, 4'd10);

    step("bne.fetch", 6'b000000, 1'b1, 4'd1, V_F1, 4'd1);
`ifdef MC_CTRL_BNE_EN
    step("bne.dec",   6'b000101, 1'b0, 4'd2,  V_DEC, 4'd2);
    step("bne.br",    6'b000000, 1'b0, 4'd13, V_BNE, 4'd13);
`else
    step("bne.dec",   6'b000101, 1'b0, 4'd2, V_DILL, 4'd2);
    step("bne.ret",   6'b000000, 1'b0, 4'd1, V_F0,   4'd0);
`endif

    // illegal opcode: main returns to FETCH, wide instance parks in IDLE first
    step("ill.fetch", 6'b000000, 1'b1, 4'd1, V_F1,   4'd1);
    step("ill.dec",   6'b111111, 1'b0, 4'd2, V_DILL, 4'd2);
    step("ill.ret",   6'b111111, 1'b0, 4'd1, V_F0,   4'd0);

    // lw abandoned by reset while waiting in MEMRD
    step("rst.fetch", 6'b000000, 1'b1, 4'd1, V_F1,  4'd1);
    step("rst.dec",   6'b100011, 1'b0, 4'd2, V_DEC, 4'd2);
    step("rst.adr",   6'b000000, 1'b0, 4'd3, V_ADR, 4'd3);
    step("rst.rd",    6'b000000, 1'b0, 4'd4, V_MRD, 4'd4);
    #1;
    reset     = 1'b1;
    mem_ready = 1'b1;
    expect_now("rst.async", 4'd0, V_ZERO, 4'd0);
    @(negedge clk);
    expect_now("rst.hold", 4'd0, V_ZERO, 4'd0);
    reset = 1'b0;
    step("rst.rel",  6'b000000, 1'b0, 4'd1, V_F0,  4'd1);
    step("rst.go",   6'b000000, 1'b1, 4'd1, V_F1,  4'd1);
    step("rst.dec",  6'b000100, 1'b0, 4'd2, V_DEC, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
